// File: rtl/qoi_pkg.sv
// Shared QOI constants and helpers for the chunk window and the pixel decoder.
package qoi_pkg;

  localparam int unsigned HDR_LEN   = 14;
  localparam logic [31:0] QOI_MAGIC = 32'h716F6966;

  localparam logic [1:0] OP_INDEX = 2'b00;
  localparam logic [1:0] OP_DIFF  = 2'b01;
  localparam logic [1:0] OP_LUMA  = 2'b10;
  localparam logic [1:0] OP_RUN   = 2'b11;
  localparam logic [7:0] OP_RGB   = 8'hFE;
  localparam logic [7:0] OP_RGBA  = 8'hFF;

  typedef enum logic [1:0] {
    ST_HEADER,
    ST_STREAM,
    ST_BAD
  } qoi_state_e;

  // Total bytes of the op whose first byte is op (tag byte included).
  function automatic logic [2:0] qoi_op_len(input logic [7:0] op);
    logic [2:0] len;
    len = 3'd1;
    unique case (op[7:6])
      OP_INDEX, OP_DIFF, OP_RUN: len = 3'd1;
      OP_LUMA:                   len = 3'd2;
    endcase
    if (op == OP_RGB)  len = 3'd4;
    if (op == OP_RGBA) len = 3'd5;
    return len;
  endfunction

  function automatic logic [7:0] qoi_magic_byte(input logic [1:0] idx);
    logic [7:0] b;
    unique case (idx)
      2'd0: b = QOI_MAGIC[31:24];
      2'd1: b = QOI_MAGIC[23:16];
      2'd2: b = QOI_MAGIC[15:8];
      2'd3: b = QOI_MAGIC[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/qoi_chunk_window_if.sv
// Byte-stream input and chunk-window output between file feeder, window and decoder.
interface qoi_chunk_window_if;

  logic [7:0]      in_data;
  logic            in_valid;
  logic            in_ready;
  logic [4:0][7:0] chunk;
  logic            chunk_valid;
  logic [2:0]      consume;

  modport master (
    output in_data, in_valid, consume,
    input  in_ready, chunk, chunk_valid
  );

  modport slave (
    input  in_data, in_valid, consume,
    output in_ready, chunk, chunk_valid
  );

endinterface

// File: rtl/qoi_byte_window.sv
// DEPTH-byte shift buffer: retires consume bytes from the front and appends one byte per cycle.
module qoi_byte_window #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned FW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic [2:0]            consume,
  output logic [DEPTH-1:0][7:0] win,
  output logic [FW-1:0]         fill
);

  localparam int unsigned BW = DEPTH * 8;

  logic [DEPTH-1:0][7:0] win_q;
  logic [FW-1:0]         fill_q;
  logic [FW-1:0]         base;
  logic                  over;
  logic [BW-1:0]         shifted;
  logic [BW-1:0]         keep;
  logic [BW-1:0]         ins;
  logic [5:0]            sh_k;
  logic [FW+2:0]         sh_b;

  // Over-consume empties the window; the push then lands at entry 0.
  always_comb begin
    over    = FW'(consume) > fill_q;
    base    = over ? '0 : fill_q - FW'(consume);
    sh_k    = {consume, 3'b000};
    sh_b    = {base, 3'b000};
    shifted = over ? '0 : (win_q >> sh_k);
    keep    = ~({BW{1'b1}} << sh_b);
    ins     = push ? (BW'(push_data) << sh_b) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_q  <= '0;
      fill_q <= '0;
    end else begin
      win_q  <= (shifted & keep) | ins;
      fill_q <= base + FW'(push);
    end
  end

  assign win  = win_q;
  assign fill = fill_q;

endmodule

// File: rtl/qoi_chunk_window.sv
// QOI file front end: parses the 14-byte header, then feeds body bytes to the decoder as a 5-byte chunk window.
module qoi_chunk_window #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned HDR_LEN = qoi_pkg::HDR_LEN
) (
  input  logic               clk,
  input  logic               rst,
  qoi_chunk_window_if.slave  bus,
  output logic [31:0]        img_width,
  output logic [31:0]        img_height,
  output logic [7:0]         img_channels,
  output logic [7:0]         img_colorspace,
  output logic               header_done,
  output logic               magic_err,
  output logic               consume_err
);

  import qoi_pkg::*;

  localparam int unsigned FW = $clog2(DEPTH + 1);
  localparam int unsigned HW = $clog2(HDR_LEN);

  qoi_state_e            state;
  logic [HW-1:0]         hcnt;
  logic                  rdy_en;
  logic [DEPTH-1:0][7:0] win;
  logic [FW-1:0]         fill;
  logic                  hs;
  logic                  push;
  logic [2:0]            k_eff;
  logic                  cons_bad;
  logic [2:0]            need_len;

  always_comb begin
    hs       = bus.in_valid && bus.in_ready;
    push     = hs && (state == ST_STREAM);
    k_eff    = (state == ST_STREAM) ? bus.consume : 3'd0;
    cons_bad = (state == ST_STREAM) ? (FW'(bus.consume) > fill) : (bus.consume != 3'd0);
    need_len = qoi_op_len(win[0]);
  end

  // rdy_en keeps in_ready low through reset and releases it on the first clock after.
  assign bus.in_ready    = rdy_en && ((state != ST_STREAM) || (fill < FW'(DEPTH)));
  assign bus.chunk       = win[4:0];
  assign bus.chunk_valid = (state == ST_STREAM) && (fill >= FW'(need_len));

  qoi_byte_window #(
    .DEPTH (DEPTH),
    .FW    (FW)
  ) u_window (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.in_data),
    .consume   (k_eff),
    .win       (win),
    .fill      (fill)
  );

  // Header parser; BAD is terminal until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_HEADER;
      hcnt           <= '0;
      rdy_en         <= 1'b0;
      img_width      <= '0;
      img_height     <= '0;
      img_channels   <= '0;
      img_colorspace <= '0;
      header_done    <= 1'b0;
      magic_err      <= 1'b0;
      consume_err    <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (cons_bad) consume_err <= 1'b1;
      if ((state == ST_HEADER) && hs) begin
        hcnt <= hcnt + HW'(1);
        if (hcnt < HW'(4)) begin
          if (bus.in_data != qoi_magic_byte(hcnt[1:0])) begin
            magic_err <= 1'b1;
            state     <= ST_BAD;
          end
        end else if (hcnt < HW'(8)) begin
          img_width <= {img_width[23:0], bus.in_data};
        end else if (hcnt < HW'(12)) begin
          img_height <= {img_height[23:0], bus.in_data};
        end else if (hcnt == HW'(12)) begin
          img_channels <= bus.in_data;
        end
        if (hcnt == HW'(HDR_LEN - 1)) begin
          img_colorspace <= bus.in_data;
          header_done    <= 1'b1;
          state          <= ST_STREAM;
        end
      end
    end
  end

endmodule
